// File: rtl/mtx_resp.sv
// mtx_resp -- responder end of the matrix-operand fetch handshake.
//
// The systolic MMULT controller raises mtx_mreq with a word address on
// mtxaddr and holds both until it sees datack. This block wins the local RAM
// read port through the RAM arbiter (ram_req/ram_gnt), captures the returned
// word into mtx_data and pulses datack for one cycle while mtx_data is stable.
//
// Handshake semantics: mtx_mreq is a level request that is sampled only in
// IDLE; datack is a single-cycle acknowledge marking the one cycle mtx_data
// belongs to the request. On the RAM side ram_req is a level request held
// with a stable ram_addr until ram_gnt is seen high; ram_rdata is taken in
// the cycle after that grant. ram_gnt is ignored while ram_req is low.
//
// Optional build macro: MTX_RESP_BUFFER_EN adds a one-entry read buffer
// (tag/valid/data) that answers a repeated address without touching the RAM,
// kept coherent by snooping local RAM writes (ram_wr/ram_waddr).
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   mtx_mreq, mtxaddr   fetch request and word address from the controller
//   datack, mtx_data    one-cycle acknowledge and registered data word
//   mtx_busy            high whenever the FSM is not IDLE
//   ram_req, ram_addr   read request/address to the local RAM arbiter
//   ram_gnt, ram_rdata  arbiter grant and read data (one cycle after grant)
//   ram_wr, ram_waddr   local RAM write snoop (used only by the buffer)
//   state_dbg           current FSM state (IDLE=0, ARB=1, DATA=2, ACK=3)
module mtx_resp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mtx_mreq,
  input  logic [ADDR_W-1:0] mtxaddr,
  output logic              datack,
  output logic [DATA_W-1:0] mtx_data,
  output logic              mtx_busy,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_gnt,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_wr,
  input  logic [ADDR_W-1:0] ram_waddr,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_rdata;

`ifdef MTX_RESP_BUFFER_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;
  logic              wr_hits_tag;

  // A write to the buffered address in the lookup cycle wins over the hit,
  // so the request is fetched fresh from RAM.
  assign wr_hits_tag = ram_wr && (ram_waddr == buf_tag);
  assign buf_hit     = buf_valid && (buf_tag == mtxaddr) && !wr_hits_tag;
  assign buf_rdata   = buf_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == DATA) begin
      // DATA always moves to ACK, so this is the fill point. A write to the
      // same word in this cycle makes the captured data stale: keep it
      // invalid. A write in the following ACK cycle is caught by the tag
      // compare below.
      buf_tag   <= addr_q;
      buf_data  <= ram_rdata;
      buf_valid <= !(ram_wr && (ram_waddr == addr_q));
    end else if (wr_hits_tag) begin
      buf_valid <= 1'b0;
    end
  end
`else
  logic unused_snoop;

  assign buf_hit      = 1'b0;
  assign buf_rdata    = '0;
  assign unused_snoop = ^{ram_wr, ram_waddr};
`endif

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (mtx_mreq) state_nx = buf_hit ? ACK : ARB;
      ARB:  if (ram_gnt)  state_nx = DATA;
      DATA: state_nx = ACK;
      ACK:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      mtx_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && mtx_mreq) begin
        addr_q <= mtxaddr;
        if (buf_hit) mtx_data <= buf_rdata;
      end
      if (state == DATA) mtx_data <= ram_rdata;
    end
  end

  // Outputs are either registers or pure decodes of the state register.
  assign ram_req   = (state == ARB);
  assign ram_addr  = addr_q;
  assign datack    = (state == ACK);
  assign mtx_busy  = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: doc/mtx_resp.md
Name: mtx_resp

Overview:
- Responder end of the GPU matrix-operand fetch handshake (mtx_mreq / mtxaddr / datack) driven by the systolic MMULT controller.
- Accepts a word-address request, wins the local RAM read port through the RAM arbiter, and returns the 32-bit word.
- Pulses datack for exactly one cycle while the word is stable on mtx_data.
- Sits between the systolic controller and the GPU local RAM arbiter.

Parameters:
- ADDR_W, 10, word-address width (local RAM byte address bits 11:2)
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- mtx_mreq  in  1  matrix fetch request; requester holds it until datack
- mtxaddr  in  ADDR_W  requested word address; valid whenever mtx_mreq is high
- datack  out  1  one-cycle data acknowledge; mtx_data is valid in this cycle
- mtx_data  out  DATA_W  returned word, registered
- mtx_busy  out  1  high in any state other than IDLE
- ram_req  out  1  read request to the local RAM arbiter
- ram_addr  out  ADDR_W  read address; held while ram_req is high
- ram_gnt  in  1  arbiter grant, sampled only while ram_req is high
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after the grant
- ram_wr  in  1  snoop: a write to local RAM this cycle
- ram_waddr  in  ADDR_W  snoop write address

Behaviour:
- Reset values: datack=0, mtx_data=0, ram_req=0, ram_addr=0, mtx_busy=0, state=IDLE, buffer invalid.
- Reset asserted mid-operation aborts any fetch immediately. No datack is issued for the aborted request.
- All outputs are registered, or decoded from state only.
- FSM states: IDLE, ARB, DATA, ACK.
- IDLE:
  - If mtx_mreq=1 and there is no buffer hit: latch mtxaddr into addr_q and go to ARB.
  - If mtx_mreq=0: stay in IDLE.
- ARB:
  - ram_req=1 and ram_addr=addr_q.
  - ram_gnt=1 goes to DATA; otherwise stay in ARB. There is no timeout.
  - ram_req drops on the cycle the FSM enters DATA.
- DATA: capture ram_rdata into mtx_data, then go to ACK.
- ACK:
  - datack=1 for exactly this cycle, then go to IDLE.
  - mtx_mreq is ignored in ACK. The requester re-presents its advanced address in the following cycle.
- Minimum latency with an immediate grant: mtx_mreq sampled in IDLE at cycle 0, ARB at cycle 1, DATA at cycle 2, datack at cycle 3.
- Each cycle ram_gnt is held low adds one cycle to that latency.
- Back-to-back requests: a request re-sampled in the IDLE cycle after ACK gives at most one fetch in flight and a 4-cycle throughput per word.
- mtxaddr changes while the FSM is outside IDLE are ignored; addr_q is the address that was latched.
- ram_gnt seen outside ARB is ignored.
- ram_wr has no effect on the FSM unless the optional feature is compiled in.

Optional Feature:
- Macro: MTX_RESP_BUFFER_EN.
- When defined, a one-entry read buffer is added (tag = ADDR_W bits, valid bit, data = DATA_W bits).
- Fill: on a DATA→ACK transition, write the tag and data and set valid.
- Exception to fill: if ram_wr hits addr_q in the DATA or ACK cycle, do not set valid.
- Hit: in IDLE with mtx_mreq=1, valid=1, and tag equal to mtxaddr:
  - load mtx_data from the buffer and go straight to ACK (datack at cycle 1);
  - ram_req is never asserted.
- Invalidate: ram_wr=1 with ram_waddr equal to tag clears valid in the same cycle.
- If that write coincides with a hit lookup, the lookup is a miss and the fetch goes to ARB.
- Reset clears valid.
- When the macro is undefined: no buffer, and every request takes the ARB path.

Test Plan:
- Reset, then mtx_mreq=1 with mtxaddr=0x004 and ram_gnt tied high → ram_req high in cycle 1 only, with ram_addr=0x004. Driving ram_rdata=0xDEADBEEF in cycle 2 → datack=1 and mtx_data=0xDEADBEEF in cycle 3 only.
- Grant held low for 5 cycles → ram_req and ram_addr stable for 6 cycles, and datack arrives 5 cycles later than the minimum. Changing mtxaddr during ARB leaves ram_addr unchanged.
- Requester stream with addresses 0x010, 0x011, 0x012, each re-asserted the cycle after datack → three datacks 4 cycles apart with the correct words. mtx_mreq held high during ACK causes no extra fetch.
- Reset asserted in DATA → the next cycle shows datack=0, ram_req=0, mtx_data=0 and IDLE. A subsequent request completes normally.
- MTX_RESP_BUFFER_EN: fetch 0x020, then request 0x020 again → datack 1 cycle after the request and no ram_req. With ram_wr to 0x020 in between → full 3-cycle fetch.
- MTX_RESP_BUFFER_EN: ram_wr to 0x030 in the same cycle as a hit lookup on 0x030 → treated as a miss, ram_req asserted, and the new RAM data returned.
